// File: rtl/bdi_decomp_stream.sv
// bdi_decomp_stream: two-stage streaming base-delta-immediate line decompressor.
// Stage 1 captures the encoded line. Stage 2 registers the expanded line.
// The block also counts completed output lines and lines carrying a reserved encoding.
module bdi_decomp_stream #(
   parameter int unsigned LINE_BYTES = 32,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [8*LINE_BYTES+19:0]  in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [8*LINE_BYTES-1:0]   out_line,
   output logic                      out_err,
   output logic [CNT_W-1:0]          line_cnt,
   output logic [CNT_W-1:0]          err_cnt
);

   localparam int unsigned W  = 8 * LINE_BYTES;
   localparam int unsigned N8 = W / 64;
   localparam int unsigned N4 = W / 32;
   localparam int unsigned N2 = W / 16;

   logic             s1_valid_q;
   logic [3:0]       s1_enc_q;
   logic [15:0]      s1_flags_q;
   logic [W-1:0]     s1_pay_q;

   logic             out_valid_q;
   logic [W-1:0]     out_line_q;
   logic             out_err_q;
   logic [CNT_W-1:0] line_cnt_q;
   logic [CNT_W-1:0] err_cnt_q;

   logic [W-1:0]     exp_line_d;
   logic             exp_err_d;
   logic             s2_load;

   logic [W-1:0]     sh;
   logic [63:0]      d64;
   logic [31:0]      d32;
   logic [15:0]      d16;
   logic [3:0]       fi;
   int unsigned      dw;

   assign s2_load  = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_load;

   // Stage 1: capture the encoded line on an input transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_enc_q   <= in_data[3:0];
            s1_flags_q <= in_data[19:4];
            s1_pay_q   <= in_data[W+19:20];
         end
      end
   end

   // Expand the stage-1 line according to its encoding.
   always_comb begin
      exp_line_d = '0;
      exp_err_d  = 1'b0;
      sh         = '0;
      d64        = '0;
      d32        = '0;
      d16        = '0;
      fi         = '0;
      dw         = 0;
      case (s1_enc_q)
         4'd0: begin
         end
         4'd1, 4'd2, 4'd3: begin
            dw = (s1_enc_q == 4'd1) ? 8 : ((s1_enc_q == 4'd2) ? 16 : 32);
            for (int unsigned i = 0; i < N8; i++) begin
               sh  = s1_pay_q >> (64 + i * dw);
               d64 = {32'd0, sh[31:0]} & ((64'd1 << dw) - 64'd1);
               exp_line_d[i*64 +: 64] = s1_flags_q[i[3:0]] ? s1_pay_q[63:0] + d64
                                                           : s1_pay_q[63:0] - d64;
            end
         end
         4'd4, 4'd5: begin
            dw = (s1_enc_q == 4'd4) ? 8 : 16;
            for (int unsigned i = 0; i < N4; i++) begin
               sh  = s1_pay_q >> (32 + i * dw);
               d32 = sh[31:0] & ((32'd1 << dw) - 32'd1);
               exp_line_d[i*32 +: 32] = s1_flags_q[i[3:0]] ? s1_pay_q[31:0] + d32
                                                           : s1_pay_q[31:0] - d32;
            end
         end
         4'd6: begin
            // word 0 is the bare base; word i uses delta/flag slot i-1
            exp_line_d[15:0] = s1_pay_q[15:0];
            for (int unsigned i = 1; i < N2; i++) begin
               sh  = s1_pay_q >> (16 + (i - 1) * 8);
               d16 = {8'd0, sh[7:0]};
               fi  = 4'(i - 1);
               exp_line_d[i*16 +: 16] = s1_flags_q[fi] ? s1_pay_q[15:0] + d16
                                                       : s1_pay_q[15:0] - d16;
            end
         end
         4'd7: begin
            for (int unsigned i = 0; i < N8; i++) begin
               exp_line_d[i*64 +: 64] = s1_pay_q[63:0];
            end
         end
         4'd8: begin
            exp_line_d = s1_pay_q;
         end
         4'd9: begin
            for (int unsigned i = 0; i < N4; i++) begin
               exp_line_d[i*32 +: 32] = s1_pay_q[31:0];
            end
         end
         default: begin
            exp_err_d = 1'b1;
         end
      endcase
   end

   // Stage 2: register the expanded line whenever the output slot is free or draining.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_line_q  <= '0;
         out_err_q   <= 1'b0;
      end else if (s2_load) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_line_q <= exp_line_d;
            out_err_q  <= exp_err_d;
         end
      end
   end

   // Statistics: count completed output transfers and those flagged as errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else if (out_valid_q && out_ready) begin
         line_cnt_q <= line_cnt_q + CNT_W'(1);
         if (out_err_q) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_line  = out_line_q;
   assign out_err   = out_err_q;
   assign line_cnt  = line_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bdi_decomp_stream.sv
// Testbench for bdi_decomp_stream: directed vectors with hand-computed lines,
// then a backpressured stream with a mid-stream reset against a small reference model.
module tb_bdi_decomp_stream;

   localparam int unsigned W = 256;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W+19:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_line;
   logic          out_err;
   logic [15:0]   line_cnt;
   logic [15:0]   err_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   bdi_decomp_stream #(.LINE_BYTES(32), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_line  (out_line),
      .out_err   (out_err),
      .line_cnt  (line_cnt),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_out_line",  out_line,      W'(0));
      chk("rst_out_err",   W'(out_err),   W'(0));
      chk("rst_line_cnt",  W'(line_cnt),  W'(0));
      chk("rst_err_cnt",   W'(err_cnt),   W'(0));
      chk("rst_in_ready",  W'(in_ready),  W'(1));
   endtask

   // Sends one line into an empty pipeline and checks the 2-cycle latency and result.
   task automatic send(input string tag, input logic [3:0] enc, input logic [15:0] fl,
                       input logic [W-1:0] pay, input logic [W-1:0] exp_l, input logic exp_e);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = {pay, fl, enc};
      #1;
      chk({tag, "_in_ready"}, W'(in_ready), W'(1));
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk({tag, "_early"}, W'(out_valid), W'(0));
      @(negedge clk);
      #1;
      chk({tag, "_valid"}, W'(out_valid), W'(1));
      chk({tag, "_line"},  out_line,      exp_l);
      chk({tag, "_err"},   W'(out_err),   W'(exp_e));
   endtask

   function automatic logic [W:0] ref_line(input logic [3:0] enc, input logic [W-1:0] p);
      case (enc)
         4'd0:    ref_line = '0;
         4'd7:    ref_line = {1'b0, {4{p[63:0]}}};
         4'd8:    ref_line = {1'b0, p};
         4'd9:    ref_line = {1'b0, {8{p[31:0]}}};
         default: ref_line = {1'b1, {W{1'b0}}};
      endcase
   endfunction

   initial begin
      logic [W-1:0] p;
      logic [W-1:0] e;
      logic [W:0]   q[$];
      logic [W:0]   ex;
      logic [3:0]   enc;
      logic [3:0]   enc_tab[5];
      int           sent;
      int           e_post;
      bit           pending;
      bit           done_rst;

      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      do_reset();

      // enc 0: random flags and payload give an all-zero line
      p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send("enc0", 4'd0, 16'($urandom), p, W'(0), 1'b0);

      // enc 1: upper flag bits set but ignored
      p = '0;
      p[63:0] = 64'h1000;
      p[64 +: 32] = 32'h04030201;
      e = {64'h0FFC, 64'h1003, 64'h0FFE, 64'h1001};
      send("enc1", 4'd1, 16'hABC5, p, e, 1'b0);

      // enc 2
      p = '0;
      p[63:0] = 64'h100;
      p[64 +: 16] = 16'h0001;
      p[80 +: 16] = 16'h0200;
      p[96 +: 16] = 16'hFFFF;
      p[112 +: 16] = 16'h0010;
      e = {64'h110, 64'h100FF, 64'hFFFF_FFFF_FFFF_FF00, 64'hFF};
      send("enc2", 4'd2, 16'h000C, p, e, 1'b0);

      // enc 3
      p = '0;
      p[63:0] = 64'h1_0000_0000;
      p[64 +: 32] = 32'h1;
      p[96 +: 32] = 32'hFFFF_FFFF;
      p[128 +: 32] = 32'h8000_0000;
      p[160 +: 32] = 32'h0;
      e = {64'h1_0000_0000, 64'h0_8000_0000, 64'h1_FFFF_FFFF, 64'h1_0000_0001};
      send("enc3", 4'd3, 16'h0003, p, e, 1'b0);

      // enc 4
      p = '0;
      p[31:0] = 32'h10;
      p[32 +: 64] = {8{8'h20}};
      e = {4{32'h30, 32'hFFFF_FFF0}};
      send("enc4", 4'd4, 16'h00AA, p, e, 1'b0);

      // enc 5
      p = '0;
      p[31:0] = 32'h8000_0000;
      p[32 +: 128] = {8{16'hFFFF}};
      e = {{4{32'h7FFF_0001}}, {4{32'h8000_FFFF}}};
      send("enc5", 4'd5, 16'h000F, p, e, 1'b0);

      // enc 6: every word past word 0 wraps to zero
      p = '0;
      p[15:0] = 16'hFFFF;
      p[16 +: 120] = {15{8'h01}};
      e = W'(16'hFFFF);
      send("enc6", 4'd6, 16'hFFFF, p, e, 1'b0);

      // enc 9 then enc 8
      p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 32'hDEADBEEF};
      send("enc9", 4'd9, 16'($urandom), p, {8{32'hDEADBEEF}}, 1'b0);
      p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send("enc8", 4'd8, 16'($urandom), p, p, 1'b0);

      // reserved encoding and counters
      do_reset();
      send("enc12", 4'd12, 16'h1234, {8{32'hFFFF_FFFF}}, W'(0), 1'b1);
      chk("enc12_line_cnt_pre", W'(line_cnt), W'(0));
      chk("enc12_err_cnt_pre",  W'(err_cnt),  W'(0));
      @(negedge clk);
      #1;
      chk("enc12_line_cnt", W'(line_cnt), W'(1));
      chk("enc12_err_cnt",  W'(err_cnt),  W'(1));

      // stream of 40 lines with random backpressure and reset after line 20
      do_reset();
      enc_tab = '{4'd0, 4'd7, 4'd8, 4'd9, 4'd12};
      sent = 0;
      e_post = 0;
      pending = 1'b0;
      done_rst = 1'b0;
      for (int cyc = 0; cyc < 3000 && (sent < 40 || q.size() > 0); cyc++) begin
         @(negedge clk);
         if (sent == 20 && !done_rst && !pending) begin
            rst = 1'b1;
            in_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            q.delete();
            done_rst = 1'b1;
            #1;
            chk("mid_rst_line_cnt",  W'(line_cnt),  W'(0));
            chk("mid_rst_err_cnt",   W'(err_cnt),   W'(0));
            chk("mid_rst_out_valid", W'(out_valid), W'(0));
            continue;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         if (!pending && sent < 40) begin
            enc = enc_tab[$urandom_range(0, 4)];
            p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            in_data = {p, 16'($urandom), enc};
            in_valid = 1'b1;
            pending = 1'b1;
         end
         if (!pending) in_valid = 1'b0;
         #1;
         if (in_valid && in_ready) begin
            ex = ref_line(in_data[3:0], in_data[W+19:20]);
            q.push_back(ex);
            if (done_rst && ex[W]) e_post++;
            sent++;
            pending = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("stream_unexpected_out", W'(1), W'(0));
            end else begin
               ex = q.pop_front();
               chk("stream_line", out_line,    ex[W-1:0]);
               chk("stream_err",  W'(out_err), W'(ex[W]));
            end
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("stream_sent",     W'(sent),     W'(40));
      chk("stream_drained",  W'(q.size()), W'(0));
      chk("stream_line_cnt", W'(line_cnt), W'(20));
      chk("stream_err_cnt",  W'(err_cnt),  W'(e_post));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
